// File: rtl/mul4_rr_sched.sv
// Two-requester round-robin scheduler sharing one combinational 4x4 unsigned
// array multiplier. A granted operand pair is registered, the array is given a
// programmable settle window, and the product is offered on a valid/ready port
// tagged with the id of the requester that owns it.
module mul4_rr_sched #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       gnt1,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_p,
  output logic       res_id,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Unsigned shift-and-add array: one partial-product row per multiplier bit.
  function automatic logic [7:0] mul4(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc + ({4'h0, a} << i);
    end
    return acc;
  endfunction

  state_t     r_state;
  logic       r_ptr;
  logic [3:0] r_opa;
  logic [3:0] r_opb;
  logic [2:0] r_cnt;
  logic       r_gnt0;
  logic       r_gnt1;
  logic       r_res_valid;
  logic [7:0] r_res_p;
  logic       r_res_id;
  logic       r_busy;

  logic       w_any_req;
  logic       w_pick1;
  logic [7:0] w_prod;

  // Requester 1 wins when it is alone, or when both ask and 0 was served last.
  assign w_any_req = req0 | req1;
  assign w_pick1   = req1 & (~req0 | ~r_ptr);
  assign w_prod    = mul4(r_opa, r_opb);

  // Scheduler FSM: arbitration, operand capture, settle countdown, result hold.
  // The counter is loaded with SETTLE so the product is captured on the edge
  // after the settle window expires, giving a latency of SETTLE+1 edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b1;
      r_opa       <= 4'h0;
      r_opb       <= 4'h0;
      r_cnt       <= 3'd0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_p     <= 8'h00;
      r_res_id    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_opa    <= w_pick1 ? a1 : a0;
            r_opb    <= w_pick1 ? b1 : b0;
            r_res_id <= w_pick1;
            r_ptr    <= w_pick1;
            r_gnt0   <= ~w_pick1;
            r_gnt1   <= w_pick1;
            r_cnt    <= 3'(SETTLE);
            r_busy   <= 1'b1;
            r_state  <= CALC;
          end
        end
        CALC: begin
          if (r_cnt == 3'd0) begin
            r_res_p     <= w_prod;
            r_res_valid <= 1'b1;
            r_state     <= HOLD;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        HOLD: begin
          if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign res_valid = r_res_valid;
  assign res_p     = r_res_p;
  assign res_id    = r_res_id;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mul4_rr_sched.sv
// Bench for mul4_rr_sched: one instance with SETTLE=1 and one with SETTLE=3,
// driven by directed and random transactions against a transaction-level model.
module tb_mul4_rr_sched;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic       req0 [2];
  logic [3:0] a0   [2];
  logic [3:0] b0   [2];
  logic       gnt0 [2];
  logic       req1 [2];
  logic [3:0] a1   [2];
  logic [3:0] b1   [2];
  logic       gnt1 [2];
  logic       res_valid [2];
  logic       res_ready [2];
  logic [7:0] res_p  [2];
  logic       res_id [2];
  logic       busy   [2];

  int nvec;
  int nerr;
  int last_served [2];
  int settle_of   [2];

  mul4_rr_sched #(.SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0[0]), .a0(a0[0]), .b0(b0[0]), .gnt0(gnt0[0]),
    .req1(req1[0]), .a1(a1[0]), .b1(b1[0]), .gnt1(gnt1[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]),
    .res_p(res_p[0]), .res_id(res_id[0]), .busy(busy[0])
  );

  mul4_rr_sched #(.SETTLE(3)) u_s3 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0[1]), .a0(a0[1]), .b0(b0[1]), .gnt0(gnt0[1]),
    .req1(req1[1]), .a1(a1[1]), .b1(b1[1]), .gnt1(gnt1[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]),
    .res_p(res_p[1]), .res_id(res_id[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int d, input string tag);
    chk({tag, "_valid"}, 32'(res_valid[d]), 32'd0);
    chk({tag, "_busy"},  32'(busy[d]),      32'd0);
    chk({tag, "_gnt0"},  32'(gnt0[d]),      32'd0);
    chk({tag, "_gnt1"},  32'(gnt1[d]),      32'd0);
  endtask

  // One transaction on instance d, called at a negedge with that instance idle.
  // The winner follows the round-robin rule; its product, id and latency
  // (SETTLE+1 edges after acceptance) come from plain arithmetic.
  task automatic run_op(input int d, input bit r0, input bit r1,
                        input logic [3:0] x0, input logic [3:0] y0,
                        input logic [3:0] x1, input logic [3:0] y1,
                        input int stall, input bit keep_loser, input string tag);
    int win;
    int n;
    logic [7:0] exp_p;
    win = (r0 && r1) ? ((last_served[d] == 1) ? 0 : 1) : (r0 ? 0 : 1);
    exp_p = (win == 0) ? 8'(int'(x0) * int'(y0)) : 8'(int'(x1) * int'(y1));
    req0[d] = r0; a0[d] = x0; b0[d] = y0;
    req1[d] = r1; a1[d] = x1; b1[d] = y1;
    res_ready[d] = (stall == 0);
    @(negedge clk);
    chk({tag, "_gnt0"}, 32'(gnt0[d]), 32'(win == 0));
    chk({tag, "_gnt1"}, 32'(gnt1[d]), 32'(win == 1));
    chk({tag, "_busy"}, 32'(busy[d]), 32'd1);
    last_served[d] = win;
    if (win == 0) req0[d] = 1'b0; else req1[d] = 1'b0;
    if (!keep_loser) begin
      req0[d] = 1'b0;
      req1[d] = 1'b0;
    end
    n = 0;
    while (!res_valid[d] && n < 20) begin
      @(negedge clk);
      n++;
      if (gnt0[d] || gnt1[d]) chk({tag, "_gnt_pulse"}, {gnt0[d], gnt1[d]}, 32'd0);
    end
    chk({tag, "_latency"}, 32'(n), 32'(settle_of[d] + 1));
    chk({tag, "_p"},  32'(res_p[d]),  32'(exp_p));
    chk({tag, "_id"}, 32'(res_id[d]), 32'(win));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(res_valid[d]), 32'd1);
      chk({tag, "_hold_p"},     32'(res_p[d]),     32'(exp_p));
      chk({tag, "_hold_id"},    32'(res_id[d]),    32'(win));
      chk({tag, "_hold_busy"},  32'(busy[d]),      32'd1);
      chk({tag, "_hold_gnt"},   {gnt0[d], gnt1[d]}, 32'd0);
    end
    res_ready[d] = 1'b1;
    @(negedge clk);
    chk({tag, "_ack_valid"}, 32'(res_valid[d]), 32'd0);
    chk({tag, "_ack_busy"},  32'(busy[d]),      32'd0);
  endtask

  initial begin
    int d;
    int pat;
    nvec = 0;
    nerr = 0;
    settle_of[0] = 1;
    settle_of[1] = 3;
    clk_en = 1'b0;
    rst_n  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1'b0; a0[i] = 4'h0; b0[i] = 4'h0;
      req1[i] = 1'b0; a1[i] = 4'h0; b1[i] = 4'h0;
      res_ready[i] = 1'b1;
      last_served[i] = 1;
    end

    // Reset with the clock stopped.
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk_idle(i, "rst");
      chk("rst_p", 32'(res_p[i]), 32'h00);
    end
    #3 rst_n = 1'b1;
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle(0, "post_rst0");
    chk_idle(1, "post_rst1");

    // Contention from reset, then alternation, then re-raise both.
    run_op(0, 1, 1, 4'h3, 4'h5, 4'hF, 4'hF, 0, 1, "cont_a");
    run_op(0, 0, 1, 4'h3, 4'h5, 4'hF, 4'hF, 0, 0, "cont_b");
    run_op(0, 1, 1, 4'h3, 4'h5, 4'hF, 4'hF, 0, 0, "cont_c");

    // Single request, SETTLE=1.
    run_op(0, 1, 0, 4'hF, 4'hA, 4'h0, 4'h0, 0, 0, "single");

    // Backpressure with the other requester kept waiting, then served next.
    run_op(0, 1, 1, 4'h7, 4'h9, 4'hC, 4'hD, 5, 1, "bp");
    run_op(0, 1, 0, 4'h7, 4'h9, 4'h0, 4'h0, 0, 0, "bp_next");

    // Zero operand, SETTLE=3.
    run_op(1, 0, 1, 4'h0, 4'h0, 4'h0, 4'hA, 0, 0, "zero");

    // Asynchronous reset while SETTLE=3 instance is mid-calculation.
    req1[1] = 1'b1; a1[1] = 4'h5; b1[1] = 4'h5;
    @(negedge clk);
    chk("arst_gnt1", 32'(gnt1[1]), 32'd1);
    req1[1] = 1'b0;
    @(negedge clk);
    chk("arst_busy_before", 32'(busy[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle(1, "arst");
    chk("arst_p", 32'(res_p[1]), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    last_served[0] = 1;
    last_served[1] = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("arst_no_result", {res_valid[1], busy[1]}, 32'd0);
    end

    // Random transactions on either instance.
    for (int t = 0; t < 24; t++) begin
      d   = int'($urandom_range(0, 1));
      pat = int'($urandom_range(1, 3));
      run_op(d, pat[0], pat[1],
             4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
             int'($urandom_range(0, 3)), 1'b0, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
